// File: rtl/core_idecode_pkg.sv
// Shared constants and types for the RV32I ALU-class decode stage.
package core_idecode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [9:0] ALU_CODE_SUM = {F7_BASE, F3_ADD};

    // Decoded instruction as held in the pipeline register.
    typedef struct packed {
        logic [9:0]  opcode_alu;
        logic [31:0] alu_i1;
        logic [31:0] alu_i2;
        logic [4:0]  rd;
        logic        wb_en;
        logic        illegal;
    } ex_payload_t;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SR);
    endfunction

endpackage

// File: rtl/core_idecode_if.sv
// Fetch-side and execute-side handshake bundle around the decode stage.
interface core_idecode_if;
    logic        IF_VALID;
    logic        IF_READY;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic        FLUSH;
    logic [4:0]  RS1_ADDR;
    logic [4:0]  RS2_ADDR;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic        EX_VALID;
    logic        EX_READY;
    logic [9:0]  EX_OPCODE_ALU;
    logic [31:0] EX_ALU_I1;
    logic [31:0] EX_ALU_I2;
    logic [4:0]  EX_RD;
    logic        EX_WB_EN;
    logic        EX_ILLEGAL;

    modport master (
        output IF_VALID, IF_INSTR, IF_PC, FLUSH, RS1_DATA, RS2_DATA, EX_READY,
        input  IF_READY, RS1_ADDR, RS2_ADDR, EX_VALID, EX_OPCODE_ALU,
               EX_ALU_I1, EX_ALU_I2, EX_RD, EX_WB_EN, EX_ILLEGAL
    );

    modport slave (
        input  IF_VALID, IF_INSTR, IF_PC, FLUSH, RS1_DATA, RS2_DATA, EX_READY,
        output IF_READY, RS1_ADDR, RS2_ADDR, EX_VALID, EX_OPCODE_ALU,
               EX_ALU_I1, EX_ALU_I2, EX_RD, EX_WB_EN, EX_ILLEGAL
    );
endinterface

// File: rtl/core_imm_gen.sv
// Combinational I/U-immediate and shift-amount extraction from the upper instruction bits.
module core_imm_gen (
    input  logic [31:12] instr_hi,
    output logic [31:0]  imm_i,
    output logic [31:0]  imm_u,
    output logic [31:0]  shamt
);
    assign imm_i = {{20{instr_hi[31]}}, instr_hi[31:20]};
    assign imm_u = {instr_hi[31:12], 12'b0};
    assign shamt = {27'b0, instr_hi[24:20]};
endmodule

// File: rtl/core_idecode.sv
// RV32I ALU-class decode stage: legality check, operand muxing and one-entry valid/ready register.
module core_idecode
    import core_idecode_pkg::*;
(
    input  logic         CLK,
    input  logic         NRST,
    core_idecode_if.slave bus
);
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_u, shamt;
    logic        legal;
    ex_payload_t nxt, ex_q;
    logic        ex_valid;
    logic        accept;

    assign instr = bus.IF_INSTR;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];

    assign bus.RS1_ADDR = instr[19:15];
    assign bus.RS2_ADDR = instr[24:20];

    core_imm_gen u_imm_gen (
        .instr_hi (instr[31:12]),
        .imm_i    (imm_i),
        .imm_u    (imm_u),
        .shamt    (shamt)
    );

    // All accepted opcodes end in 2'b11, so the opcode compare also rejects compressed words.
    always_comb begin
        legal          = 1'b0;
        nxt            = '0;
        nxt.opcode_alu = ALU_CODE_SUM;
        nxt.rd         = instr[11:7];
        unique case (opc)
            OPC_LUI: begin
                legal      = 1'b1;
                nxt.alu_i2 = imm_u;
            end
            OPC_AUIPC: begin
                legal      = 1'b1;
                nxt.alu_i1 = bus.IF_PC;
                nxt.alu_i2 = imm_u;
            end
            OPC_OP_IMM: begin
                nxt.alu_i1 = bus.RS1_DATA;
                if (f3 == F3_SLL) begin
                    legal          = (f7 == F7_BASE);
                    nxt.alu_i2     = shamt;
                    nxt.opcode_alu = {F7_BASE, f3};
                end else if (f3 == F3_SR) begin
                    legal          = (f7 == F7_BASE) || (f7 == F7_ALT);
                    nxt.alu_i2     = shamt;
                    nxt.opcode_alu = {f7, f3};
                end else begin
                    legal          = 1'b1;
                    nxt.alu_i2     = imm_i;
                    nxt.opcode_alu = {F7_BASE, f3};
                end
            end
            OPC_OP: begin
                legal = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
                nxt.alu_i1     = bus.RS1_DATA;
                // The ALU shifts by the whole operand, so only rs2[4:0] may reach it.
                nxt.alu_i2     = is_shift(f3) ? {27'b0, bus.RS2_DATA[4:0]} : bus.RS2_DATA;
                nxt.opcode_alu = {f7, f3};
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            nxt.opcode_alu = ALU_CODE_SUM;
            nxt.alu_i1     = '0;
            nxt.alu_i2     = '0;
        end
        nxt.illegal = !legal;
        nxt.wb_en   = legal && (instr[11:7] != 5'd0);
    end

    assign bus.IF_READY = !bus.FLUSH && (!ex_valid || bus.EX_READY);
    assign accept       = bus.IF_VALID && bus.IF_READY;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
        end else if (bus.FLUSH) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_q     <= nxt;
        end else if (bus.EX_READY) begin
            ex_valid <= 1'b0;
        end
    end

    assign bus.EX_VALID      = ex_valid;
    assign bus.EX_OPCODE_ALU = ex_q.opcode_alu;
    assign bus.EX_ALU_I1     = ex_q.alu_i1;
    assign bus.EX_ALU_I2     = ex_q.alu_i2;
    assign bus.EX_RD         = ex_q.rd;
    assign bus.EX_WB_EN      = ex_q.wb_en;
    assign bus.EX_ILLEGAL    = ex_q.illegal;
endmodule
